// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants, scoreboard slot types and the RAW hazard compare.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;
  localparam logic [1:0] TNEW_ZERO = 2'd0;

  // Producer sitting in E: destination, remaining Tnew, MDU start flags.
  typedef struct packed {
    logic [REG_W-1:0] wa;
    logic [1:0]       tnew;
    logic             md_start;
    logic             md_div;
  } e_slot_t;

  // Producer sitting in M: only destination and remaining Tnew matter.
  typedef struct packed {
    logic [REG_W-1:0] wa;
    logic [1:0]       tnew;
  } m_slot_t;

  // A source stalls when an in-flight producer of it won't be forwardable
  // before the consumer needs it. Register 0 and unused sources never stall.
  function automatic logic raw_hazard(input logic [REG_W-1:0] src,
                                      input logic [1:0]       tuse,
                                      input e_slot_t          e,
                                      input m_slot_t          m);
    raw_hazard = (src != '0) && (tuse != TUSE_NONE) &&
                 (((e.wa == src) && (e.tnew > tuse)) ||
                  ((m.wa == src) && (m.tnew > tuse)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// MDU busy window: reloads when a mult/div sits in E, counts down after.
module md_busy_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_div,
  output logic md_busy
);

  localparam int CW = $clog2(DIV_CYC + 1);

  logic [CW-1:0] md_cnt;

  // Load the op latency as it leaves E; otherwise drain to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               md_cnt <= '0;
    else if (md_start)        md_cnt <= md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    else if (md_cnt != '0)    md_cnt <= md_cnt - 1'b1;
  end

  // Busy while the op is in E and for the whole countdown.
  assign md_busy = md_start | (md_cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble controller for the 5-stage pipeline with shadow E/M scoreboard.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic [REG_W-1:0] d_wa,
  input  logic [1:0]       d_tnew,
  input  logic             d_md,
  input  logic             d_md_start,
  input  logic             d_md_div,
  output logic             stall,
  output logic             pc_we,
  output logic             fd_we,
  output logic             de_clr,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  e_slot_t e_slot;
  m_slot_t m_slot;
  logic    haz_rs, haz_rt, haz_md;

  md_busy_timer #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) u_md_timer (
    .clk      (clk),
    .reset    (reset),
    .md_start (e_slot.md_start),
    .md_div   (e_slot.md_div),
    .md_busy  (md_busy)
  );

  // Hazard decision is same-cycle combinational from slot state and D fields.
  always_comb begin
    haz_rs = raw_hazard(d_rs, d_tuse_rs, e_slot, m_slot);
    haz_rt = raw_hazard(d_rt, d_tuse_rt, e_slot, m_slot);
    haz_md = d_md & md_busy;
    stall  = haz_rs | haz_rt | haz_md;
  end

  assign pc_we  = ~stall;
  assign fd_we  = ~stall;
  assign de_clr = stall;

  // E slot takes the D instruction, or a bubble when D is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     e_slot <= '0;
    else if (stall) e_slot <= '0;
    else            e_slot <= '{wa: d_wa, tnew: d_tnew,
                                md_start: d_md_start, md_div: d_md_div};
  end

  // M slot follows E unconditionally, one cycle closer to forwardable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) m_slot <= '0;
    else        m_slot <= '{wa: e_slot.wa,
                            tnew: (e_slot.tnew == TNEW_ZERO) ? TNEW_ZERO
                                                             : e_slot.tnew - 2'd1};
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    stall_cnt <= '0;
    else if (stall && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench: table vectors, directed MDU/reset sequences, random vs. queue model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int MC = 5, DC = 10;

  logic       clk = 1'b0, reset = 1'b0;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md, d_md_start, d_md_div;
  logic       stall, pc_we, fd_we, de_clr, md_busy;
  logic [31:0] stall_cnt;
  logic        s_stall, s_pc_we, s_fd_we, s_de_clr, s_md_busy;
  logic [2:0]  s_cnt;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wa(d_wa), .d_tnew(d_tnew),
    .d_md(d_md), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .stall(stall), .pc_we(pc_we), .fd_we(fd_we), .de_clr(de_clr),
    .md_busy(md_busy), .stall_cnt(stall_cnt));

  // Narrow counter copy so saturation is reachable.
  pipe_hazard_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC), .CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wa(d_wa), .d_tnew(d_tnew),
    .d_md(d_md), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .stall(s_stall), .pc_we(s_pc_we), .fd_we(s_fd_we), .de_clr(s_de_clr),
    .md_busy(s_md_busy), .stall_cnt(s_cnt));

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  // Every instruction that entered E is remembered with the cycle it did so;
  // its age now tells where it is and how much of its Tnew remains.
  typedef struct {
    logic [4:0] wa; int tnew; bit md_start; bit md_div; int cyc;
  } inst_t;
  inst_t flight[$];
  int t = 0, busy_until = -1, m_cnt = 0;

  function automatic void model_reset();
    flight.delete(); t = 0; busy_until = -1; m_cnt = 0;
  endfunction

  function automatic bit src_blocked(input logic [4:0] src, input int tuse);
    bit b = 0;
    if (src == 0 || tuse == 3) return 0;
    foreach (flight[i]) begin
      int age = t - flight[i].cyc;
      int r;
      if (age < 0 || age > 1) continue;
      r = flight[i].tnew - age; if (r < 0) r = 0;
      if (flight[i].wa == src && r > tuse) b = 1;
    end
    return b;
  endfunction

  function automatic bit model_busy();
    bit b = (t <= busy_until);
    foreach (flight[i]) if (flight[i].cyc == t && flight[i].md_start) b = 1;
    return b;
  endfunction

  function automatic void model_edge(input bit st);
    inst_t n;
    foreach (flight[i])
      if (flight[i].cyc == t && flight[i].md_start)
        busy_until = t + (flight[i].md_div ? DC : MC);
    if (st) m_cnt++;
    else begin
      n.wa = d_wa; n.tnew = int'(d_tnew); n.md_start = d_md_start;
      n.md_div = d_md_div; n.cyc = t + 1;
      flight.push_back(n);
    end
    t++;
    while (flight.size() > 0 && flight[0].cyc < t - 1) void'(flight.pop_front());
  endfunction

  // ---------------- drive / sample ----------------
  logic       obs_stall, obs_busy;
  logic [31:0] obs_cnt;

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tr, input logic [1:0] tt,
                       input logic [4:0] wa, input logic [1:0] tn,
                       input logic md, input logic ms, input logic dv);
    d_rs = rs; d_rt = rt; d_tuse_rs = tr; d_tuse_rt = tt;
    d_wa = wa; d_tnew = tn; d_md = md; d_md_start = ms; d_md_div = dv;
  endtask

  task automatic nop();  set_d(0, 0, 3, 3, 0, 0, 0, 0, 0); endtask
  task automatic mult(); set_d(0, 0, 3, 3, 0, 0, 1, 1, 0); endtask
  task automatic divi(); set_d(0, 0, 3, 3, 0, 0, 1, 1, 1); endtask
  task automatic mflo(); set_d(0, 0, 3, 3, 5, TNEW_ALU, 1, 0, 0); endtask

  // One clock with inputs already applied: compare against the model mid-cycle.
  task automatic cycle(input string tag);
    bit es, eb;
    int sc;
    es = src_blocked(d_rs, int'(d_tuse_rs)) || src_blocked(d_rt, int'(d_tuse_rt))
         || (d_md && model_busy());
    eb = model_busy();
    @(negedge clk);
    obs_stall = stall; obs_busy = md_busy; obs_cnt = stall_cnt;
    chk({tag, "_stall"},   32'(stall),   32'(es));
    chk({tag, "_pc_we"},   32'(pc_we),   32'(!es));
    chk({tag, "_fd_we"},   32'(fd_we),   32'(!es));
    chk({tag, "_de_clr"},  32'(de_clr),  32'(es));
    chk({tag, "_md_busy"}, 32'(md_busy), 32'(eb));
    chk({tag, "_cnt"},     stall_cnt,    32'(m_cnt));
    sc = (m_cnt > 7) ? 7 : m_cnt;
    chk({tag, "_cnt_sat"}, 32'(s_cnt),   32'(sc));
    @(posedge clk);
    model_edge(es);
    #1;
  endtask

  // Hold D until it issues; returns how many cycles it stalled.
  task automatic hold_count(input string tag, output int n);
    bit done = 0;
    n = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      cycle(tag);
      if (obs_stall) n++; else done = 1;
    end
    if (!done) chk({tag, "_timeout"}, 32'(n), 32'(0));
  endtask

  typedef struct packed {
    logic [4:0] rs, rt; logic [1:0] tr, tt; logic [4:0] wa; logic [1:0] tn;
    logic md, ms, dv, es; logic [7:0] ec;
  } vec_t;
  vec_t vt [19];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic [1:0] tr, input logic [1:0] tt,
                              input logic [4:0] wa, input logic [1:0] tn,
                              input logic es, input logic [7:0] ec);
    vec_t v;
    v.rs = rs; v.rt = rt; v.tr = tr; v.tt = tt; v.wa = wa; v.tn = tn;
    v.md = 0; v.ms = 0; v.dv = 0; v.es = es; v.ec = ec;
    return v;
  endfunction

  initial begin
    int n;
    // lw/add, lw/beq, addu/beq, reg0, unused source, rt hazard via M
    vt[0]  = mk(2, 0, 1, 3, 1, TNEW_LOAD, 0, 0);
    vt[1]  = mk(1, 3, 1, 1, 2, TNEW_ALU,  1, 0);
    vt[2]  = mk(1, 3, 1, 1, 2, TNEW_ALU,  0, 1);
    vt[3]  = mk(0, 0, 3, 3, 0, TNEW_ZERO, 0, 1);
    vt[4]  = mk(0, 0, 3, 3, 0, TNEW_ZERO, 0, 1);
    vt[5]  = mk(2, 0, 1, 3, 1, TNEW_LOAD, 0, 1);
    vt[6]  = mk(1, 0, 0, 0, 0, TNEW_ZERO, 1, 1);
    vt[7]  = mk(1, 0, 0, 0, 0, TNEW_ZERO, 1, 2);
    vt[8]  = mk(1, 0, 0, 0, 0, TNEW_ZERO, 0, 3);
    vt[9]  = mk(0, 0, 3, 3, 0, TNEW_ZERO, 0, 3);
    vt[10] = mk(5, 6, 1, 1, 4, TNEW_ALU,  0, 3);
    vt[11] = mk(4, 0, 0, 0, 0, TNEW_ZERO, 1, 3);
    vt[12] = mk(4, 0, 0, 0, 0, TNEW_ZERO, 0, 4);
    vt[13] = mk(5, 6, 1, 1, 4, TNEW_ALU,  0, 4);
    vt[14] = mk(0, 0, 0, 0, 0, TNEW_ZERO, 0, 4);
    vt[15] = mk(2, 0, 1, 3, 7, TNEW_LOAD, 0, 4);
    vt[16] = mk(7, 7, 3, 3, 0, TNEW_ZERO, 0, 4);
    vt[17] = mk(0, 7, 3, 0, 0, TNEW_ZERO, 1, 4);
    vt[18] = mk(0, 7, 3, 0, 0, TNEW_ZERO, 0, 5);

    nop();
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_pc_we", 32'(pc_we), 1);
    chk("rst_de_clr", 32'(de_clr), 0);
    chk("rst_md_busy", 32'(md_busy), 0);
    chk("rst_cnt", stall_cnt, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();

    for (int i = 0; i < 19; i++) begin
      set_d(vt[i].rs, vt[i].rt, vt[i].tr, vt[i].tt, vt[i].wa, vt[i].tn,
            vt[i].md, vt[i].ms, vt[i].dv);
      cycle("vec");
      chk("vec_tbl_stall", 32'(obs_stall), 32'(vt[i].es));
      chk("vec_tbl_cnt", obs_cnt, 32'(vt[i].ec));
    end

    // mult then mflo: 6 stall cycles
    mult(); cycle("mul");
    mflo(); hold_count("mul_mflo", n);
    chk("mul_mflo_stalls", 32'(n), 6);
    chk("mul_mflo_busy_end", 32'(obs_busy), 0);
    nop(); cycle("gap");

    // div then mfhi: 11 stall cycles
    divi(); cycle("div");
    mflo(); hold_count("div_mfhi", n);
    chk("div_mfhi_stalls", 32'(n), 11);
    nop(); cycle("gap");

    // back-to-back mult: second waits 6, then the window restarts at full length
    mult(); cycle("mm1");
    mult(); hold_count("mm2", n);
    chk("mm2_stalls", 32'(n), 6);
    mflo(); hold_count("mm_mflo", n);
    chk("mm_mflo_stalls", 32'(n), 6);
    nop(); cycle("gap");

    // async reset in the middle of a divide
    divi(); cycle("rdiv");
    nop(); repeat (4) cycle("rdiv_run");
    mflo();
    @(negedge clk);
    chk("rdiv_pre_stall", 32'(stall), 1);
    chk("rdiv_pre_busy", 32'(md_busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("rdiv_rst_busy", 32'(md_busy), 0);
    chk("rdiv_rst_stall", 32'(stall), 0);
    chk("rdiv_rst_cnt", stall_cnt, 0);
    chk("rdiv_rst_pc_we", 32'(pc_we), 1);
    chk("rdiv_rst_de_clr", 32'(de_clr), 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    cycle("post_rst");
    chk("post_rst_mflo", 32'(obs_stall), 0);

    // random traffic; D is held while stalled, as the pipeline would
    obs_stall = 0;
    for (int i = 0; i < 400; i++) begin
      if (!obs_stall) begin
        logic md, ms;
        md = ($urandom_range(3) == 0);
        ms = md & $urandom_range(1);
        set_d(5'($urandom_range(7)), 5'($urandom_range(7)),
              2'($urandom_range(3)), 2'($urandom_range(3)),
              5'($urandom_range(7)), 2'($urandom_range(2)),
              md, ms, 1'($urandom_range(1)));
      end
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Stall/bubble controller for the 5-stage pipeline.
- Decides each cycle whether the F/D register and PC hold and whether the D/E register loads a bubble.
- Keeps its own shadow scoreboard of the destination register and remaining Tnew for the instructions in E and M.
- Sequences the multi-cycle mult/div unit's busy window; sits beside the D-stage decoder and drives the write-enable/clear pins of the PC, F/D and D/E registers.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu leaves E
- DIV_CYC, 10, busy cycles after a div/divu leaves E
- CNT_W, 32, width of the stall-cycle performance counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- d_rs  in  5  D-stage rs index
- d_rt  in  5  D-stage rt index
- d_tuse_rs  in  2  cycles until D instr needs rs (0..2; 3 = unused)
- d_tuse_rt  in  2  same for rt
- d_wa  in  5  D-stage destination register (0 = none)
- d_tnew  in  2  cycles after entering E until result forwardable (ALU 1, load 2, jal/lui-at-D 0)
- d_md  in  1  D instr touches HI/LO/MDU (mult/div/mfhi/mflo/mthi/mtlo)
- d_md_start  in  1  D instr is mult/multu/div/divu
- d_md_div  in  1  with d_md_start: 1 = div, 0 = mult
- stall  out  1  hazard detected this cycle
- pc_we  out  1  = !stall
- fd_we  out  1  = !stall
- de_clr  out  1  = stall (D/E loads NOP)
- md_busy  out  1  MDU occupied
- stall_cnt  out  CNT_W  total stall cycles since reset

Behaviour:
- State: E slot {e_wa, e_tnew, e_md_start, e_md_div}, M slot {m_wa, m_tnew}, md_cnt (ceil log2(DIV_CYC+1) bits), stall_cnt.
- Reset low (async): all slots cleared (wa 0, tnew 0, flags 0), md_cnt 0, stall_cnt 0. While in reset: stall 0, pc_we 1, fd_we 1, de_clr 0, md_busy 0, stall_cnt 0.
- Each rising edge, not stalled: E slot <= D fields.
- Each rising edge, stalled: E slot <= bubble (wa 0, tnew 0, md flags 0).
- Always: M slot <= {e_wa, e_tnew==0 ? 0 : e_tnew-1}. W is not tracked (Tnew 0).
- md_cnt: if e_md_start, load e_md_div ? DIV_CYC : MULT_CYC; else if md_cnt != 0, decrement; else hold 0.
- md_busy = e_md_start | (md_cnt != 0). Combinational from state.
- Hazard on rs: d_rs != 0 and d_tuse_rs != 3, and either (e_wa == d_rs and e_tnew > d_tuse_rs) or (m_wa == d_rs and m_tnew > d_tuse_rs). Hazard on rt is the same with rt fields.
- MDU hazard: d_md & md_busy.
- stall = rs hazard | rt hazard | MDU hazard. Purely combinational, same cycle; no registered latency on stall.
- stall_cnt increments by 1 on each edge where stall = 1; saturates at all-ones, no wrap.
- Register 0 never causes a stall, even if a slot holds wa 0.
- E and M both matching the same register: stall if either slot requires it; the younger (E) producer dominates forwarding, not handled here.
- d_md_start while md_busy: stalls like any other MDU op; a new mult cannot restart a running op.
- Reset asserted mid-operation: md_busy drops asynchronously; the pipeline resumes with empty slots on release.

Decomposition:
- Shared constants file: TUSE_NONE = 2'd3, TNEW_ALU = 2'd1, TNEW_LOAD = 2'd2, TNEW_ZERO = 2'd0, register index width 5.
- One natural sub-module: md_busy_timer (md_cnt load/decrement, md_busy output).
- Scoreboard slots and compare logic stay inline.

Test Plan:
- lw $1 (tnew 2) then add $2,$1,$3 (tuse_rs 1) -> stall high exactly 1 cycle, de_clr 1 that cycle, stall_cnt = 1.
- lw $1 then beq $1,$0 (tuse_rs 0) -> stall for 2 consecutive cycles (E then M), then release; stall_cnt = 2.
- addu $4 (tnew 1) then beq $4 (tuse 0) -> 1 stall. Same pair with d_rs = 0 -> 0 stalls.
- mult then mflo -> stall 6 cycles (1 with mult in E, then md_cnt 5..1); md_busy falls on the 7th cycle. div then mfhi -> 11 cycles.
- Back-to-back mult, mult -> second holds in D for 6 cycles, then enters E; md_cnt reloads 5.
- Reset low during div with md_cnt = 7 -> md_busy and stall drop to 0 immediately; stall_cnt = 0. After release, mflo proceeds with no stall.
